// File: rtl/updown_ctr_bank.sv
// updown_ctr_bank: NCH independent edge-triggered up/down counters that saturate (WRAP=0) or wrap (WRAP=1).
// Define UPDOWN_CTR_SYNC_EN to add 2-flop synchronizers on inc/dec, which gives 3-cycle latency instead of 1.
// Note for users: a request held high through reset release counts once on the first edge after release.
module updown_ctr_bank #(
  parameter int NCH    = 4,
  parameter int MAXVAL = 15,
  parameter int WRAP   = 0,
  localparam int W     = ($clog2(MAXVAL + 1) < 1) ? 1 : $clog2(MAXVAL + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   inc,
  input  logic [NCH-1:0]   dec,
  input  logic [NCH-1:0]   clr,
  output logic [NCH*W-1:0] count,
  output logic [NCH-1:0]   at_max,
  output logic [NCH-1:0]   at_min,
  output logic [NCH-1:0]   evt
);

  localparam logic [W-1:0] MAXV = W'(MAXVAL);

  logic [NCH-1:0]   inc_smp, dec_smp;
  logic [NCH-1:0]   prev_inc_q, prev_dec_q;
  logic [NCH-1:0]   inc_e, dec_e;
  logic [NCH*W-1:0] count_q, count_d;
  logic [NCH-1:0]   at_max_q, at_max_d;
  logic [NCH-1:0]   at_min_q, at_min_d;
  logic [NCH-1:0]   evt_q, evt_d;

`ifdef UPDOWN_CTR_SYNC_EN
  logic [NCH-1:0] inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc_s1_q <= '0;
      inc_s2_q <= '0;
      dec_s1_q <= '0;
      dec_s2_q <= '0;
    end else begin
      inc_s1_q <= inc;
      inc_s2_q <= inc_s1_q;
      dec_s1_q <= dec;
      dec_s2_q <= dec_s1_q;
    end
  end

  assign inc_smp = inc_s2_q;
  assign dec_smp = dec_s2_q;
`else
  assign inc_smp = inc;
  assign dec_smp = dec;
`endif

  assign inc_e = inc_smp & ~prev_inc_q;
  assign dec_e = dec_smp & ~prev_dec_q;

  // Flags and evt come from the next count so they update on the same edge as count.
  always_comb begin
    count_d  = count_q;
    at_max_d = '0;
    at_min_d = '0;
    evt_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) begin
        count_d[i*W +: W] = '0;
      end else if (inc_e[i] && !dec_e[i]) begin
        if (count_q[i*W +: W] == MAXV) begin
          count_d[i*W +: W] = (WRAP != 0) ? '0 : MAXV;
        end else begin
          count_d[i*W +: W] = count_q[i*W +: W] + W'(1);
        end
      end else if (dec_e[i] && !inc_e[i]) begin
        if (count_q[i*W +: W] == '0) begin
          count_d[i*W +: W] = (WRAP != 0) ? MAXV : '0;
        end else begin
          count_d[i*W +: W] = count_q[i*W +: W] - W'(1);
        end
      end
      at_max_d[i] = (count_d[i*W +: W] == MAXV);
      at_min_d[i] = (count_d[i*W +: W] == '0);
      evt_d[i]    = (count_d[i*W +: W] != count_q[i*W +: W]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      at_max_q   <= '0;
      at_min_q   <= '1;
      evt_q      <= '0;
      prev_inc_q <= '0;
      prev_dec_q <= '0;
    end else begin
      count_q    <= count_d;
      at_max_q   <= at_max_d;
      at_min_q   <= at_min_d;
      evt_q      <= evt_d;
      prev_inc_q <= inc_smp;
      prev_dec_q <= dec_smp;
    end
  end

  assign count  = count_q;
  assign at_max = at_max_q;
  assign at_min = at_min_q;
  assign evt    = evt_q;

endmodule

// File: tb/tb_updown_ctr_bank.sv
// Directed bench for updown_ctr_bank: saturating bank (NCH=4, MAXVAL=22) and wrapping bank (NCH=2, MAXVAL=7).
// Latency-aware, so it also covers a build with UPDOWN_CTR_SYNC_EN defined.
module tb_updown_ctr_bank;
`ifdef UPDOWN_CTR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  inc0 = '0, dec0 = '0, clr0 = '0;
  logic [19:0] count0;
  logic [3:0]  at_max0, at_min0, evt0;
  logic [1:0]  inc1 = '0, dec1 = '0, clr1 = '0;
  logic [5:0]  count1;
  logic [1:0]  at_max1, at_min1, evt1;

  always #5 clk = ~clk;

  updown_ctr_bank #(.NCH(4), .MAXVAL(22), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(rst_n), .inc(inc0), .dec(dec0), .clr(clr0),
    .count(count0), .at_max(at_max0), .at_min(at_min0), .evt(evt0)
  );

  updown_ctr_bank #(.NCH(2), .MAXVAL(7), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(rst_n), .inc(inc1), .dec(dec1), .clr(clr1),
    .count(count1), .at_max(at_max1), .at_min(at_min1), .evt(evt1)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  inc, dec, clr;
    logic [19:0] cnt;
    logic [3:0]  evt, mx, mn;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [3:0] i, input logic [3:0] d, input logic [3:0] c,
                              input logic [4:0] c3, input logic [4:0] c2, input logic [4:0] c1,
                              input logic [4:0] c0, input logic [3:0] e, input logic [3:0] mx,
                              input logic [3:0] mn);
    vec_t v;
    v.inc = i; v.dec = d; v.clr = c;
    v.cnt = {c3, c2, c1, c0};
    v.evt = e; v.mx = mx; v.mn = mn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse0(input logic [3:0] im, input logic [3:0] dm);
    inc0 = im; dec0 = dm;
    tick(LAT);
    inc0 = '0; dec0 = '0;
    tick(LAT);
  endtask

  task automatic pulse1(input logic [1:0] im, input logic [1:0] dm);
    inc1 = im; dec1 = dm;
    tick(LAT);
    inc1 = '0; dec1 = '0;
    tick(LAT);
  endtask

  initial begin
    int nevt;
    logic [2:0] other_evt;
    int lat;
    bit found;
    logic [3:0] exp_evt;

    //               inc   dec   clr    c3 c2 c1 c0      evt   max   min
    vecs[0]  = mk(4'h1, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd1, 4'h1, 4'h0, 4'hE);
    vecs[1]  = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd1, 4'h0, 4'h0, 4'hE);
    vecs[2]  = mk(4'h1, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd2, 4'h1, 4'h0, 4'hE);
    vecs[3]  = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd2, 4'h0, 4'h0, 4'hE);
    vecs[4]  = mk(4'h2, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h2, 4'h0, 4'hC);
    vecs[5]  = mk(4'h2, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h0, 4'h0, 4'hC);
    vecs[6]  = mk(4'h2, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h0, 4'h0, 4'hC);
    vecs[7]  = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h0, 4'h0, 4'hC);
    vecs[8]  = mk(4'h4, 4'h4, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h0, 4'h0, 4'hC);
    vecs[9]  = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd2, 4'h0, 4'h0, 4'hC);
    vecs[10] = mk(4'h0, 4'h1, 4'h0, 5'd0, 5'd0, 5'd1, 5'd1, 4'h1, 4'h0, 4'hC);
    vecs[11] = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd1, 4'h0, 4'h0, 4'hC);
    vecs[12] = mk(4'h0, 4'h4, 4'h0, 5'd0, 5'd0, 5'd1, 5'd1, 4'h0, 4'h0, 4'hC);
    vecs[13] = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd1, 5'd1, 4'h0, 4'h0, 4'hC);
    vecs[14] = mk(4'h1, 4'h2, 4'h0, 5'd0, 5'd0, 5'd0, 5'd2, 4'h3, 4'h0, 4'hE);
    vecs[15] = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd2, 4'h0, 4'h0, 4'hE);
    vecs[16] = mk(4'h0, 4'h0, 4'h1, 5'd0, 5'd0, 5'd0, 5'd0, 4'h1, 4'h0, 4'hF);
    vecs[17] = mk(4'h0, 4'h0, 4'h1, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 4'h0, 4'hF);
    vecs[18] = mk(4'h0, 4'h0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0, 4'h0, 4'h0, 4'hF);

    #12;
    chk("rst_count0", count0, 0);
    chk("rst_at_min0", at_min0, 4'hF);
    chk("rst_at_max0", at_max0, 0);
    chk("rst_evt0", evt0, 0);
    chk("rst_count1", count1, 0);
    chk("rst_at_min1", at_min1, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 19; k++) begin
      inc0 = vecs[k].inc; dec0 = vecs[k].dec; clr0 = vecs[k].clr;
      tick(LAT);
      // With synchronized inc/dec the clr pulse lands LAT-1 edges before the sample point.
      exp_evt = (LAT != 1 && vecs[k].clr != 4'h0) ? 4'h0 : vecs[k].evt;
      chk($sformatf("vec%0d_count", k), count0, vecs[k].cnt);
      chk($sformatf("vec%0d_evt", k), evt0, exp_evt);
      chk($sformatf("vec%0d_at_max", k), at_max0, vecs[k].mx);
      chk($sformatf("vec%0d_at_min", k), at_min0, vecs[k].mn);
    end
    inc0 = '0; dec0 = '0; clr0 = '0;

    // Saturation: 25 inc pulses on channel 0 with MAXVAL=22 < 2^W-1.
    nevt = 0;
    other_evt = '0;
    for (int p = 0; p < 25; p++) begin
      inc0 = 4'h1;
      for (int c = 0; c < LAT; c++) begin
        tick(1);
        nevt += int'(evt0[0]);
        other_evt |= evt0[3:1];
      end
      inc0 = 4'h0;
      for (int c = 0; c < LAT; c++) begin
        tick(1);
        nevt += int'(evt0[0]);
        other_evt |= evt0[3:1];
      end
    end
    chk("sat_count", count0, {5'd0, 5'd0, 5'd0, 5'd22});
    chk("sat_at_max", at_max0, 4'h1);
    chk("sat_evt_pulses", nevt, 22);
    chk("sat_other_evt", other_evt, 0);
    pulse0(4'h1, 4'h0);
    chk("sat_hold_count", count0[4:0], 22);
    pulse0(4'h0, 4'h1);
    chk("sat_dec_count", count0[4:0], 21);
    chk("sat_dec_at_max", at_max0, 4'h0);

    // Clear priority on channel 3.
    repeat (5) pulse0(4'h8, 4'h0);
    chk("clr_pre_count3", count0[19:15], 5);
    inc0 = 4'h8; clr0 = 4'h8;
    tick(LAT);
    chk("clr_count3", count0[19:15], 0);
    chk("clr_at_min3", at_min0[3], 1);
    clr0 = 4'h0;
    tick(2 * LAT);
    chk("clr_after_count3", count0[19:15], 0);
    chk("clr_after_evt3", evt0[3], 0);
    inc0 = 4'h0;
    tick(LAT);

    // Latency, cycle-counted on channel 1.
    inc0 = 4'h2;
    lat = 0;
    found = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (!found) begin
        tick(1);
        if (count0[9:5] != 5'd0) begin
          found = 1'b1;
          lat = n;
        end
      end
    end
    chk("latency_edges", lat, LAT);
    chk("latency_count1", count0[9:5], 1);
    inc0 = 4'h0;
    tick(LAT);

    // Wrap bank.
    repeat (7) pulse1(2'b01, 2'b00);
    chk("wrap_pre_count", count1[2:0], 7);
    chk("wrap_pre_at_max", at_max1[0], 1);
    inc1 = 2'b01;
    tick(LAT);
    chk("wrap_up_count", count1[2:0], 0);
    chk("wrap_up_evt", evt1[0], 1);
    chk("wrap_up_at_min", at_min1[0], 1);
    inc1 = 2'b00;
    tick(LAT);
    chk("wrap_up_evt_gone", evt1[0], 0);
    dec1 = 2'b01;
    tick(LAT);
    chk("wrap_dn_count", count1[2:0], 7);
    chk("wrap_dn_evt", evt1[0], 1);
    chk("wrap_dn_at_max", at_max1[0], 1);
    dec1 = 2'b00;
    tick(LAT);
    chk("wrap_other_ch", count1[5:3], 0);

    // Asynchronous reset between edges, then release with inc held high.
    repeat (9) pulse0(4'h4, 4'h0);
    chk("areset_pre_count2", count0[14:10], 9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_count0", count0, 0);
    chk("areset_at_min0", at_min0, 4'hF);
    chk("areset_at_max0", at_max0, 0);
    chk("areset_count1", count1, 0);
    inc0 = 4'h4;
    @(negedge clk);
    rst_n = 1'b1;
    tick(LAT);
    chk("release_count0", count0, {5'd0, 5'd1, 5'd0, 5'd0});
    chk("release_evt0", evt0, 4'h4);
    tick(3);
    chk("release_held_count0", count0, {5'd0, 5'd1, 5'd0, 5'd0});
    inc0 = 4'h0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
